// File: rtl/instr_prefetch_buffer_pkg.sv
// instr_prefetch_buffer_pkg: shared widths, NOP encoding, FIFO entry layout and request FSM states
package instr_prefetch_buffer_pkg;
    localparam int INSTR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, REQ_DISCARD} req_state_e;
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
    } fifo_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO holding fetched words with their PCs; flush beats push
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: credit-limited instruction prefetcher with in-order queue and
// redirect flush that drops responses still owed for the abandoned path.
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    req_state_e state, state_n;
    logic [CW-1:0] outstanding, discard_cnt, fifo_count;
    logic [CW:0] outstanding_n, fifo_count_n;
    logic [31:0] req_pc, resp_pc, addr, target, req_pc_eff;
    logic gnt_fire, push, pop, launch, credit, fifo_empty, fifo_full;
    fifo_entry_t head;

    assign imem_req_o = state != IDLE;
    assign imem_addr_o = addr;
    assign gnt_fire = imem_req_o && imem_gnt_i;
    assign target = redirect_pc_i & ~32'd3;
    assign req_pc_eff = redirect_i ? target : req_pc;
    assign push = imem_rvalid_i && discard_cnt == '0 && !redirect_i;
    assign pop = fetch_valid_o && fetch_ready_i && !redirect_i;
    assign outstanding_n = {1'b0, outstanding} + (CW+1)'(gnt_fire) - (CW+1)'(imem_rvalid_i);
    assign fifo_count_n = redirect_i ? '0 : {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
    // Credit is judged on next-cycle occupancy so a new request can follow a grant directly
    assign credit = (fifo_count_n + outstanding_n) < (CW+1)'(DEPTH)
                 && outstanding_n < (CW+1)'(MAX_OUTSTANDING);

    always_comb begin
        state_n = state;
        launch = 1'b0;
        if (state == IDLE || gnt_fire) begin
            launch = credit;
            state_n = credit ? REQ : IDLE;
        end else if (redirect_i) begin
            state_n = REQ_DISCARD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            outstanding <= '0;
            discard_cnt <= '0;
            req_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            addr <= RESET_PC;
        end else begin
            state <= state_n;
            outstanding <= outstanding_n[CW-1:0];
            discard_cnt <= redirect_i ? outstanding_n[CW-1:0]
                         : discard_cnt + CW'(state == REQ_DISCARD && gnt_fire)
                                       - CW'(imem_rvalid_i && discard_cnt != '0);
            req_pc <= launch ? req_pc_eff + 32'd4 : req_pc_eff;
            addr <= launch ? req_pc_eff : addr;
            resp_pc <= redirect_i ? target : push ? resp_pc + 32'd4 : resp_pc;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fifo_entry_t))) fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata ({imem_rdata_i, resp_pc}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fetch_valid_o = !fifo_empty;
    assign fetch_instr_o = fifo_empty ? NOP_INSTR : head.instr;
    assign fetch_pc_o = fifo_empty ? RESET_PC : head.pc;

    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop))
        else $error("instr_prefetch_buffer: FIFO overflow");
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: expected-PC scoreboard against a randomised req/gnt/rvalid memory
module tb_instr_prefetch_buffer;
    logic clk = 0, rst_n = 0, redirect = 0, ready = 0;
    logic [31:0] redirect_pc = 0;
    logic fetch_valid, imem_req, imem_gnt = 0, imem_rvalid = 0;
    logic [31:0] fetch_instr, fetch_pc, imem_addr, imem_rdata = 0;
    int checks = 0, failures = 0, cyc = 0;
    int gnt_pct = 100, rv_pct = 100;
    int first_gnt = -1, first_valid = -1, pops = 0, grants = 0;
    logic [31:0] mq[$], exp_q[$];
    logic prev_req = 0, prev_gnt = 0, prev_redir = 0;
    logic [31:0] prev_addr = 0, mon_exp = 0;

    instr_prefetch_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_ready_i (ready),
        .fetch_valid_o (fetch_valid),
        .fetch_instr_o (fetch_instr),
        .fetch_pc_o    (fetch_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // memory: in-order responses at least one cycle after grant
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            imem_gnt = 0;
            imem_rvalid = 0;
            prev_req = 0;
        end else begin
            if (prev_req && !prev_gnt) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
                end
            end
            imem_rvalid = mq.size() > 0 && $urandom_range(99) < rv_pct;
            imem_rdata = 32'h0;
            if (imem_rvalid) imem_rdata = mem_data(mq.pop_front());
            imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
            if (imem_gnt) begin
                mq.push_back(imem_addr);
                grants++;
                if (first_gnt < 0) first_gnt = cyc;
            end
            prev_req = imem_req;
            prev_gnt = imem_gnt;
            prev_addr = imem_addr;
        end
    end

    // monitor: every consumed entry must be the next PC of the current path
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_redir) begin
                checks++;
                if (fetch_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_valid: fetch_valid=%b after redirect, required 0", fetch_valid);
                end
            end
            if (fetch_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (fetch_valid === 1'b1 && ready && !redirect) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pop: pc=%h with nothing expected", fetch_pc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (fetch_pc !== mon_exp || fetch_instr !== mem_data(mon_exp)) begin
                        failures++;
                        $display("FAIL fetch_entry: pc=%h instr=%h, required pc=%h instr=%h",
                                 fetch_pc, fetch_instr, mon_exp, mem_data(mon_exp));
                    end
                end
            end
        end
        prev_redir = rst_n && redirect;
    end

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back((pc & ~32'd3) + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1;
        redirect_pc = pc;
        start_stream(pc);
        step();
        redirect = 0;
    endtask

    task automatic wait_pops(input int n, input string name);
        int target = pops + n;
        for (int i = 0; i < 2000 && pops < target; i++) step();
        checks++;
        if (pops < target) begin
            failures++;
            $display("FAIL %s: %0d entries consumed, required %0d", name, n - (target - pops), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        ready = 0;
        redirect = 0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: %b, required 0", fetch_valid); end
        if (fetch_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: %h, required 00000013", fetch_instr); end
        if (fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: %h, required 00000000", fetch_pc); end
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: %b, required 0", imem_req); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: %h, required 00000000", imem_addr); end
        start_stream(32'h0);
        grants = 0;
        first_gnt = -1;
        first_valid = -1;
        step();
        rst_n = 1;
    endtask

    task automatic test_zero_wait();
        int v = 0;
        gnt_pct = 100;
        rv_pct = 100;
        ready = 1;
        for (int i = 0; i < 50 && first_valid < 0; i++) step();
        checks++;
        if (first_valid < 0 || first_valid - first_gnt != 2) begin
            failures++;
            $display("FAIL first_latency: %0d cycles from gnt to valid, required 2", first_valid - first_gnt);
        end
        repeat (10) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) v++;
        end
        step();
        checks++;
        if (v != 10) begin failures++; $display("FAIL throughput: %0d valid cycles of 10, required 10", v); end
    endtask

    task automatic test_backpressure();
        ready = 0;
        rst_n = 0;
        step();
        grants = 0;
        start_stream(32'h0);
        rst_n = 1;
        repeat (20) step();
        checks += 3;
        if (grants != 4) begin failures++; $display("FAIL fill_grants: %0d, required 4", grants); end
        if (fetch_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: %b, required 1", fetch_valid); end
        if (imem_req !== 1'b0) begin failures++; $display("FAIL fill_req_stop: %b, required 0", imem_req); end
        ready = 1;
        wait_pops(4, "backpressure_drain");
    endtask

    task automatic test_redirect_outstanding();
        rv_pct = 0;
        for (int i = 0; i < 50 && mq.size() < 2; i++) step();
        checks++;
        if (mq.size() != 2) begin failures++; $display("FAIL outstanding_fill: %0d in flight, required 2", mq.size()); end
        do_redirect(32'h100);
        rv_pct = 100;
        wait_pops(4, "redirect_outstanding");
    endtask

    task automatic test_redirect_held();
        logic [31:0] held;
        gnt_pct = 0;
        for (int i = 0; i < 50 && !(imem_req === 1'b1 && mq.size() == 0); i++) step();
        held = imem_addr;
        do_redirect(32'h300);
        repeat (2) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== held) begin
            failures++;
            $display("FAIL held_addr: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, held);
        end
        gnt_pct = 100;
        for (int i = 0; i < 50 && !(imem_req === 1'b1 && imem_addr !== held); i++) step();
        checks++;
        if (imem_addr !== 32'h300) begin failures++; $display("FAIL held_next_addr: %h, required 00000300", imem_addr); end
        wait_pops(3, "redirect_held");
    endtask

    task automatic test_redirect_rvalid_pop();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (imem_rvalid === 1'b1 && fetch_valid === 1'b1) begin
                do_redirect(32'h400);
                done = 1;
                checks++;
                if (fetch_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_flush: valid=%b, required 0", fetch_valid); end
            end else step();
        end
        checks++;
        if (!done) begin failures++; $display("FAIL same_cycle_setup: rvalid=%b valid=%b, required both 1", imem_rvalid, fetch_valid); end
        wait_pops(4, "redirect_rvalid_pop");
    endtask

    task automatic test_back_to_back();
        do_redirect(32'h500);
        do_redirect(32'h600);
        wait_pops(4, "back_to_back");
        do_redirect(32'hffff_fff8);
        wait_pops(4, "pc_wrap");
    endtask

    task automatic test_misaligned();
        do_redirect(32'h202);
        for (int i = 0; i < 50 && imem_req !== 1'b1; i++) step();
        checks++;
        if (imem_addr !== 32'h200) begin failures++; $display("FAIL misaligned_addr: %h, required 00000200", imem_addr); end
        wait_pops(4, "misaligned");
    endtask

    task automatic test_random_stress();
        gnt_pct = 60;
        rv_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            ready = $urandom_range(3) != 0;
            if ($urandom_range(99) < 3) do_redirect($urandom());
            else step();
        end
        ready = 1;
        gnt_pct = 100;
        rv_pct = 100;
        wait_pops(8, "stress_drain");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_held();
        test_redirect_rvalid_pop();
        test_back_to_back();
        test_misaligned();
        test_random_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
